// File: rtl/ecdsa_sign_finalize.sv
// ECDSA signing back end: r = Rx mod N, s = k^-1 (z + r d) mod N.
// One bit-serial modular multiplier is time-shared by the Fermat inversion and the two products.
module ecdsa_sign_finalize #(
  parameter int W = 256,
  parameter logic [W-1:0] N =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] rx,
  input  logic [W-1:0] k,
  input  logic [W-1:0] z,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] r,
  output logic [W-1:0] s,
  output logic [2:0]   dbg_state
);

  // Handshake: start is taken only in IDLE (never queued); busy is high from
  // RED through MUL_S; done is a one-cycle FIN pulse with err/r/s valid, and
  // err/r/s stay held until the next accepted start reaches FIN.
  typedef enum logic [2:0] {IDLE, RED, CHK, INV, MUL_RD, ADD, MUL_S, FIN} state_t;

  localparam logic [W-1:0] E = N - 2;

  state_t         state_q, state_d;
  logic [W-1:0]   rx_q, k_q, z_q, d_q;
  logic [W-1:0]   kinv_q, t_q;
  logic [W-1:0]   acc_q, a_q, b_q;
  logic [8:0]     cnt_q;
  logic [7:0]     ebit_q;
  logic           sq_q;
  logic [W-1:0]   r_q, s_q;
  logic           err_q;

  logic           mul_state, mul_last, e_bit, fin_err;
  logic [W-1:0]   mul_a, mul_b, mul_res;

  function automatic logic [W-1:0] red1(input logic [W-1:0] x);
    return (x >= N) ? x - N : x;
  endfunction

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] u;
    u = {1'b0, x} + {1'b0, y};
    if (u >= {1'b0, N}) u = u - {1'b0, N};
    return u[W-1:0];
  endfunction

  // One interleaved step: acc = 2*acc mod N, then conditionally + a mod N.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc, input logic [W-1:0] a,
                                           input logic bit_i);
    logic [W:0] t2;
    t2 = {acc, 1'b0};
    if (t2 >= {1'b0, N}) t2 = t2 - {1'b0, N};
    if (bit_i) t2 = t2 + {1'b0, a};
    if (t2 >= {1'b0, N}) t2 = t2 - {1'b0, N};
    return t2[W-1:0];
  endfunction

  assign mul_state = (state_q == INV) || (state_q == MUL_RD) || (state_q == MUL_S);
  assign mul_last  = (cnt_q == 9'(W));
  assign mul_res   = mm_step(acc_q, a_q, b_q[W-1]);
  assign e_bit     = E[ebit_q];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      INV: begin
        mul_a = sq_q ? kinv_q : k_q;
        mul_b = kinv_q;
      end
      MUL_RD: begin
        mul_a = rx_q;
        mul_b = d_q;
      end
      MUL_S: begin
        mul_a = kinv_q;
        mul_b = t_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fin_err = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = RED;
      RED:    state_d = CHK;
      CHK: begin
        fin_err = 1'b1;
        state_d = ((rx_q == '0) || (k_q == '0)) ? FIN : INV;
      end
      INV:    if (mul_last && (ebit_q == 8'd0) && !(sq_q && e_bit)) state_d = MUL_RD;
      MUL_RD: if (mul_last) state_d = ADD;
      ADD:    state_d = MUL_S;
      MUL_S: begin
        fin_err = (mul_res == '0);
        if (mul_last) state_d = FIN;
      end
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE) && (state_q != FIN);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign r         = r_q;
  assign s         = s_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q   <= '0;
      k_q    <= '0;
      z_q    <= '0;
      d_q    <= '0;
      kinv_q <= '0;
      t_q    <= '0;
      ebit_q <= '0;
      sq_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          rx_q <= rx;
          k_q  <= k;
          z_q  <= z;
          d_q  <= d;
        end
        RED: begin
          rx_q <= red1(rx_q);
          k_q  <= red1(k_q);
          z_q  <= red1(z_q);
          d_q  <= red1(d_q);
        end
        CHK: begin
          kinv_q <= {{(W-1){1'b0}}, 1'b1};
          ebit_q <= 8'(W - 1);
          sq_q   <= 1'b1;
        end
        INV: if (mul_last) begin
          kinv_q <= mul_res;
          // After a squaring on a set exponent bit, the same bit still needs the multiply by k.
          if (sq_q && e_bit) begin
            sq_q <= 1'b0;
          end else begin
            sq_q   <= 1'b1;
            ebit_q <= ebit_q - 8'd1;
          end
        end
        MUL_RD: if (mul_last) t_q <= mul_res;
        ADD:    t_q <= add_mod(z_q, t_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (mul_state) begin
      if (cnt_q == 9'd0) begin
        acc_q <= '0;
        a_q   <= mul_a;
        b_q   <= mul_b;
      end else begin
        acc_q <= mul_res;
        b_q   <= {b_q[W-2:0], 1'b0};
      end
      cnt_q <= mul_last ? 9'd0 : cnt_q + 9'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Results are captured on the edge entering FIN so they are valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      s_q   <= '0;
      err_q <= 1'b0;
    end else if ((state_d == FIN) && (state_q != FIN)) begin
      err_q <= fin_err;
      r_q   <= fin_err ? '0 : rx_q;
      s_q   <= fin_err ? '0 : mul_res;
    end
  end

endmodule

// File: tb/tb_ecdsa_sign_finalize.sv
// Randomized bench for ecdsa_sign_finalize against a wide-arithmetic reference model.
module tb_ecdsa_sign_finalize;
  localparam int W = 256;
  localparam logic [W-1:0] N =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [W-1:0] GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] rx = '0, k = '0, z = '0, d = '0;
  logic         busy, done, err;
  logic [W-1:0] r, s;
  logic [2:0]   dbg_state;

  ecdsa_sign_finalize dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(rx), .k(k), .z(z), .d(d),
    .busy(busy), .done(done), .err(err), .r(r), .s(s), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_r = '0, held_s = '0;
  int           lat_full;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // reference model: plain wide arithmetic
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] aa, bb, nn, p;
    aa = {{W{1'b0}}, a};
    bb = {{W{1'b0}}, b};
    nn = {{W{1'b0}}, N};
    p  = (aa * bb) % nn;
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] powmod(input logic [W-1:0] base, input logic [W-1:0] e);
    logic [W-1:0] res, sq;
    res = 1;
    sq  = base;
    for (int i = 0; i < W; i++) begin
      if (e[i]) res = mulmod(res, sq);
      sq = mulmod(sq, sq);
    end
    return res;
  endfunction

  task automatic model(input logic [W-1:0] mrx, mk, mz, md,
                       output logic merr, output logic [W-1:0] mr, ms, output int mlat);
    logic [W-1:0]   rr, kr, zr, dr, u;
    logic [2*W-1:0] wide;
    rr = mrx % N;
    kr = mk % N;
    zr = mz % N;
    dr = md % N;
    if (rr == 0 || kr == 0) begin
      merr = 1'b1; mr = '0; ms = '0; mlat = 3;
    end else begin
      wide = ({{W{1'b0}}, zr} + {{W{1'b0}}, mulmod(rr, dr)}) % {{W{1'b0}}, N};
      u    = wide[W-1:0];
      ms   = mulmod(powmod(kr, N - 2), u);
      merr = (ms == 0);
      mr   = merr ? '0 : rr;
      if (merr) ms = '0;
      mlat = lat_full;
    end
  endtask

  // driver: one operation, optional stray start pulse at cycle poke (0 = none)
  task automatic run_op(input string tag, input logic [W-1:0] irx, ik, iz, id, input int poke);
    logic         e_err;
    logic [W-1:0] e_r, e_s;
    int           e_lat, cyc, hold_bad;
    model(irx, ik, iz, id, e_err, e_r, e_s, e_lat);
    exp_q.push_back(e_r);
    exp_q.push_back(e_s);
    @(negedge clk);
    rx = irx; k = ik; z = iz; d = id; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    hold_bad = 0;
    while (!done && cyc < e_lat + 20) begin
      if (!busy || r !== held_r || s !== held_s) hold_bad++;
      if (cyc == poke) begin
        start = 1'b1; rx = rand256(); k = rand256(); z = rand256(); d = rand256();
      end
      if (cyc == poke + 1) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_busy_hold"}, hold_bad, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cyc, e_lat);
    check({tag, "_busy_fin"}, busy, 0);
    check({tag, "_err"}, err, e_err);
    check({tag, "_r"}, r, exp_q.pop_front());
    check({tag, "_s"}, s, exp_q.pop_front());
    held_r = e_r;
    held_s = e_s;
    @(posedge clk); #1;
    check({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] e2, rk, rr;
    e2 = N - 2;
    lat_full = 4 + 257 * (258 + $countones(e2));

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_r", r, 0);
    check("rst_s", s, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", GX, 1, 5, 0, 500);
    check("basic_r_gx", r, GX);
    check("basic_s_5", s, 5);

    // early errors, issued back to back
    run_op("zero_r", 0, rand256(), rand256(), rand256(), 0);
    run_op("r_eq_n", N, rand256(), rand256(), rand256(), 0);
    run_op("zero_k", 5, N, rand256(), rand256(), 0);
    for (int i = 0; i < 4; i++) begin
      rk = ($urandom_range(0, 1) == 0) ? '0 : N;
      rr = ($urandom_range(0, 1) == 0) ? rk : rand256();
      run_op("rand_early", rr, (rr == rk) ? rand256() : rk, rand256(), rand256(), 0);
    end

    // reset while inverting: everything clears at once, no done follows
    @(negedge clk);
    rx = rand256(); k = 3; z = rand256(); d = rand256(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ($urandom_range(200, 2000)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_r", r, 0);
    check("abort_s", s, 0);
    check("abort_err", err, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held_r = '0;
    held_s = '0;

    run_op("reduce_inv", N + 7, 2, 0, 1, 0);
    check("reduce_inv_s_half", s, (N + 7) / 2);
    run_op("zero_s", 7, 1, N - 7, 1, 0);
    run_op("rand_full", rand256(), rand256(), rand256(), rand256(), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
